rr_arb8: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters. It sequences ownership by registering a 3-bit winner index and expanding it through a 3-to-8 one-hot decoder into the grant vector. It sits in front of any shared datapath element (bus, memory port, ALU) and guarantees at most one grant at a time, fair rotation, and a bounded hold time.

---
 rtl/rr_arb8_pkg.sv | 39 +++
 rtl/rr_arb8_if.sv | 14 +
 rtl/rr_arb8_onehot_dec3.sv | 14 +
 rtl/rr_arb8.sv | 85 ++++++++
 tb/tb_rr_arb8.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared types and helpers for the eight-way round-robin arbiter.
// The rotating-priority search lives here so the arbiter core reads as a plain FSM.
package rr_arb8_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [N_REQ-1:0]  req_t;
  typedef logic [HOLD_W-1:0] hold_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // First set request at or after ptr, wrapping 7 -> 0. The loop runs from the
  // farthest offset down, so the nearest offset wins.
  function automatic pick_t rr_pick(input req_t req, input idx_t ptr);
    pick_t p;
    idx_t  cand;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + idx_t'(i);
      if (req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between eight requesters and the arbiter.
interface rr_arb8_if;
  import rr_arb8_pkg::*;

  req_t req;
  req_t gnt;
  idx_t gnt_idx;
  logic gnt_valid;
  logic preempt;

  modport master (output req, input gnt, gnt_idx, gnt_valid, preempt);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, preempt);

endinterface

// File: rtl/rr_arb8_onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module onehot_dec3 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with bounded hold (MAX_HOLD, 0 = unlimited).
// Grant is a registered owner index expanded through a one-hot decoder.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arb8_if.slave  bus
);

  localparam hold_t HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam bit    HOLD_EN  = (MAX_HOLD != 0);

  state_t state, state_nxt;
  idx_t   ptr, ptr_nxt;
  idx_t   idx_q, idx_nxt;
  hold_t  hold_cnt, hold_nxt;
  logic   preempt_q, preempt_nxt;
  logic   valid;
  pick_t  pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      idx_q     <= '0;
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      idx_q     <= idx_nxt;
      hold_cnt  <= hold_nxt;
      preempt_q <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = idx_q;
    hold_nxt    = hold_cnt;
    preempt_nxt = 1'b0;
    pick        = rr_pick(bus.req, ptr);

    unique case (state)
      IDLE: begin
        if (pick.found) begin
          state_nxt = GRANT;
          idx_nxt   = pick.idx;
          hold_nxt  = hold_t'(1);
        end
      end
      GRANT: begin
        // An owner dropping req on the expiry edge is an ordinary release.
        if (!bus.req[idx_q] || (HOLD_EN && hold_cnt == HOLD_LIM)) begin
          state_nxt   = IDLE;
          ptr_nxt     = idx_q + idx_t'(1);
          idx_nxt     = '0;
          hold_nxt    = '0;
          preempt_nxt = bus.req[idx_q];
        end else if (hold_cnt != '1) begin
          hold_nxt = hold_cnt + hold_t'(1);
        end
      end
    endcase
  end

  always_comb begin
    valid         = (state == GRANT);
    bus.gnt_idx   = idx_q;
    bus.gnt_valid = valid;
    bus.preempt   = preempt_q;
  end

  onehot_dec3 u_dec (
    .sel (idx_q),
    .en  (valid),
    .y   (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: three instances cover MAX_HOLD = 16, 4 and 0.
module tb_rr_arb8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  rr_arb8_if if_a ();
  rr_arb8_if if_b ();
  rr_arb8_if if_c ();

  rr_arb8 #(.MAX_HOLD(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  rr_arb8 #(.MAX_HOLD(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  rr_arb8 #(.MAX_HOLD(0))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {gnt, gnt_idx, gnt_valid, preempt}
  function automatic logic [12:0] pk(input logic [7:0] g, input logic [2:0] i,
                                     input logic v, input logic p);
    return {g, i, v, p};
  endfunction

  function automatic logic [12:0] obs_a();
    return {if_a.gnt, if_a.gnt_idx, if_a.gnt_valid, if_a.preempt};
  endfunction

  function automatic logic [12:0] obs_b();
    return {if_b.gnt, if_b.gnt_idx, if_b.gnt_valid, if_b.preempt};
  endfunction

  function automatic logic [12:0] obs_c();
    return {if_c.gnt, if_c.gnt_idx, if_c.gnt_valid, if_c.preempt};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: {gnt,idx,valid,preempt} observed %h_%0d_%b_%b expected %h_%0d_%b_%b",
             tag, obs[12:5], obs[4:2], obs[1], obs[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Returns at a falling edge with rst_n just released; first arbitration at the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if_a.req = '0;
    if_b.req = '0;
    if_c.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [12:0] ZERO = 13'h0;

  initial begin
    logic [2:0] own;
    n_cmp = 0;
    n_err = 0;

    // Reset holds everything at zero even with every request raised.
    rst_n    = 1'b0;
    if_a.req = 8'hFF;
    if_b.req = 8'hFF;
    if_c.req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_a%0d", i), obs_a(), ZERO);
      check($sformatf("rst_b%0d", i), obs_b(), ZERO);
      check($sformatf("rst_c%0d", i), obs_c(), ZERO);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("first_a", obs_a(), pk(8'h01, 3'd0, 1'b1, 1'b0));
    check("first_b", obs_b(), pk(8'h01, 3'd0, 1'b1, 1'b0));
    check("first_c", obs_c(), pk(8'h01, 3'd0, 1'b1, 1'b0));
    if_a.req = '0;
    if_b.req = '0;
    if_c.req = '0;
    @(negedge clk);
    check("first_rel", obs_a(), ZERO);

    // Single requester 3 for five cycles; afterwards ptr=4 so 8'h09 goes to 0.
    do_reset();
    if_a.req = 8'h08;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("single%0d", i), obs_a(), pk(8'h08, 3'd3, 1'b1, 1'b0));
    end
    if_a.req = 8'h00;
    @(negedge clk);
    check("single_drop", obs_a(), ZERO);
    if_a.req = 8'h09;
    @(negedge clk);
    check("single_next", obs_a(), pk(8'h01, 3'd0, 1'b1, 1'b0));

    // Rotation from ptr=4 with req 0 and 2: order 0, 2, 0.
    do_reset();
    if_a.req = 8'h08;
    @(negedge clk);
    check("rot_setup", obs_a(), pk(8'h08, 3'd3, 1'b1, 1'b0));
    if_a.req = 8'h00;
    @(negedge clk);
    check("rot_gap0", obs_a(), ZERO);
    if_a.req = 8'h05;
    @(negedge clk);
    check("rot_g0a", obs_a(), pk(8'h01, 3'd0, 1'b1, 1'b0));
    @(negedge clk);
    check("rot_g0b", obs_a(), pk(8'h01, 3'd0, 1'b1, 1'b0));
    if_a.req = 8'h04;
    @(negedge clk);
    check("rot_gap1", obs_a(), ZERO);
    if_a.req = 8'h05;
    @(negedge clk);
    check("rot_g2a", obs_a(), pk(8'h04, 3'd2, 1'b1, 1'b0));
    @(negedge clk);
    check("rot_g2b", obs_a(), pk(8'h04, 3'd2, 1'b1, 1'b0));
    if_a.req = 8'h01;
    @(negedge clk);
    check("rot_gap2", obs_a(), ZERO);
    if_a.req = 8'h05;
    @(negedge clk);
    check("rot_g0c", obs_a(), pk(8'h01, 3'd0, 1'b1, 1'b0));

    // MAX_HOLD=4, all requesting: 4-cycle grants 0..7,0, each followed by a preempt gap.
    do_reset();
    if_b.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      own = 3'(k % 8);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("hold_k%0d_c%0d", k, c), obs_b(), pk(8'h01 << own, own, 1'b1, 1'b0));
      end
      @(negedge clk);
      check($sformatf("hold_gap%0d", k), obs_b(), pk(8'h00, 3'd0, 1'b0, 1'b1));
    end
    // Drop on the expiry edge is a normal release: no preempt.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("sim_c%0d", c), obs_b(), pk(8'h02, 3'd1, 1'b1, 1'b0));
    end
    if_b.req = 8'h00;
    @(negedge clk);
    check("sim_rel", obs_b(), ZERO);

    // MAX_HOLD=0: grant to 5 persists past hold counter saturation.
    do_reset();
    if_c.req = 8'h20;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check($sformatf("unl%0d", i), obs_c(), pk(8'h20, 3'd5, 1'b1, 1'b0));
    end
    if_c.req = 8'h00;
    @(negedge clk);
    check("unl_rel", obs_c(), ZERO);

    // Asynchronous reset in the middle of a grant clears outputs without a clock edge.
    do_reset();
    if_a.req = 8'h20;
    @(negedge clk);
    check("ar_grant", obs_a(), pk(8'h20, 3'd5, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_clear", obs_a(), ZERO);
    if_a.req = 8'h21;
    @(negedge clk);
    check("ar_held", obs_a(), ZERO);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_first", obs_a(), pk(8'h01, 3'd0, 1'b1, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
